// File: rtl/uart_ctrl_pkg.sv
// Shared constants and helpers for the byte-level UART controller.
package uart_ctrl_pkg;

  localparam int unsigned DataBits = 8;

  // Cycles per 1/16 bit; the RX deserializer oversamples at 16x.
  function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / (baud * 16);
  endfunction

endpackage

// File: rtl/uart_ctrl_if.sv
// Bridge-facing strobe/data bundle of the UART controller.
interface uart_ctrl_if;
  import uart_ctrl_pkg::*;

  logic                uart_we_n_i;
  logic                uart_re_n_i;
  logic [DataBits-1:0] uart_tx_data_i;
  logic                uart_tx_ready_o;
  logic                uart_rx_ready_o;
  logic [DataBits-1:0] uart_rx_data_o;
  logic                uart_rx_overrun_o;

  modport master (
    output uart_we_n_i, uart_re_n_i, uart_tx_data_i,
    input  uart_tx_ready_o, uart_rx_ready_o, uart_rx_data_o, uart_rx_overrun_o
  );

  modport slave (
    input  uart_we_n_i, uart_re_n_i, uart_tx_data_i,
    output uart_tx_ready_o, uart_rx_ready_o, uart_rx_data_o, uart_rx_overrun_o
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; head reads 0 while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_ctrl.sv
// 8N1 UART controller: TX shifter, 16x-oversampled RX deserializer, RX FIFO.
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  uart_ctrl_if.slave bus,
  output logic       txd,
  input  logic       rxd
);

  localparam int unsigned DIV  = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned BIT  = 16 * DIV;
  localparam int unsigned HALF = 8 * DIV;
  localparam int unsigned CntW = $clog2(BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF - 1);
  localparam logic [2:0]      LastBit  = 3'(DataBits - 1);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // ---------------- TX ----------------
  tx_state_e           tx_state_q, tx_state_d;
  logic [CntW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [2:0]          tx_bit_q, tx_bit_d;
  logic [DataBits-1:0] tx_shift_q, tx_shift_d;
  logic                txd_q, txd_d;
  logic                tx_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_wrap    = (tx_cnt_q == BitLast);
    unique case (tx_state_q)
      TxIdle: begin
        if (!bus.uart_we_n_i) begin
          tx_state_d = TxStart;
          tx_cnt_d   = '0;
          tx_shift_d = bus.uart_tx_data_i;
          txd_d      = 1'b0;
        end
      end
      TxStart: begin
        tx_cnt_d = tx_cnt_q + CntW'(1);
        if (tx_wrap) begin
          tx_state_d = TxData;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
        end
      end
      TxData: begin
        tx_cnt_d = tx_cnt_q + CntW'(1);
        if (tx_wrap) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == LastBit) begin
            tx_state_d = TxStop;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            txd_d    = tx_shift_q[1];
          end
        end
      end
      TxStop: begin
        tx_cnt_d = tx_cnt_q + CntW'(1);
        if (tx_wrap) begin
          tx_state_d = TxIdle;
          tx_cnt_d   = '0;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  assign txd                 = txd_q;
  assign bus.uart_tx_ready_o = (tx_state_q == TxIdle);

  // ---------------- RX ----------------
  logic                rxd_s1_q, rxd_s2_q;
  rx_state_e           rx_state_q, rx_state_d;
  logic [CntW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [2:0]          rx_bit_q, rx_bit_d;
  logic [DataBits-1:0] rx_shift_q, rx_shift_d;
  logic                rx_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CntW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (!rxd_s2_q) rx_state_d = RxStart;
      end
      RxStart: begin
        // Mid-start resample rejects glitches shorter than half a bit.
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_s2_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_s2_q, rx_shift_q[DataBits-1:1]};
          if (rx_bit_q == LastBit) rx_state_d = RxStop;
          else                     rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_push    = rxd_s2_q;
          rx_state_d = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // ---------------- RX FIFO and overrun ----------------
  logic rx_full, rx_empty, rx_pop_ok;
  logic overrun_q, overrun_d;

  sync_fifo #(
    .WIDTH(DataBits),
    .DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rx_push),
    .push_data(rx_shift_q),
    .pop      (!bus.uart_re_n_i),
    .full     (rx_full),
    .empty    (rx_empty),
    .head     (bus.uart_rx_data_o)
  );

  assign rx_pop_ok           = !bus.uart_re_n_i && !rx_empty;
  assign bus.uart_rx_ready_o = !rx_empty;

  always_comb begin
    overrun_d = overrun_q;
    if (rx_pop_ok)                 overrun_d = 1'b0;
    else if (rx_push && rx_full)   overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_d;
  end

  assign bus.uart_rx_overrun_o = overrun_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed + randomized bench for uart_ctrl against a frame/queue-level reference model.
module tb_uart_ctrl;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 10_000;
  localparam int unsigned RX_DEPTH = 4;
  localparam int          BIT      = 160;

  logic clk = 1'b0;
  logic rst;
  logic txd;
  logic rxd;

  uart_ctrl_if bus();

  uart_ctrl #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .RX_DEPTH(RX_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .txd(txd),
    .rxd(rxd)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model of the RX side: received bytes in order, bounded by RX_DEPTH.
  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level at cycle k (0-based) after write acceptance: start, 8 data LSB first, stop.
  function automatic logic line_bit(input logic [7:0] data, input int k);
    int idx;
    idx = k / BIT;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return data[idx-1];
  endfunction

  task automatic check_rx(input string tag);
    check({tag, "_rx_ready"}, 32'(bus.uart_rx_ready_o), 32'(exp_q.size() != 0));
    check({tag, "_rx_data"}, 32'(bus.uart_rx_data_o), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
    check({tag, "_overrun"}, 32'(bus.uart_rx_overrun_o), 32'(exp_ovr));
  endtask

  // Called right after a negedge; write is accepted at the following posedge.
  task automatic tx_frame(input logic [7:0] data, input int drop_at, input logic [7:0] drop_data);
    bus.uart_tx_data_i = data;
    bus.uart_we_n_i    = 1'b0;
    for (int k = 0; k < 10 * BIT; k++) begin
      @(negedge clk);
      if (k == drop_at) begin
        bus.uart_we_n_i    = 1'b0;
        bus.uart_tx_data_i = drop_data;
      end else begin
        bus.uart_we_n_i = 1'b1;
      end
      check("tx_line", 32'(txd), 32'(line_bit(data, k)));
      check("tx_busy", 32'(bus.uart_tx_ready_o), 32'd0);
    end
    @(negedge clk);
    check("tx_ready_back", 32'(bus.uart_tx_ready_o), 32'd1);
    check("tx_idle_line", 32'(txd), 32'd1);
  endtask

  task automatic rx_frame(input logic [7:0] data, input logic bad_stop);
    logic v;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < BIT; c++) begin
        if (b == 0)      v = 1'b0;
        else if (b == 9) v = (bad_stop && c < 100) ? 1'b0 : 1'b1;
        else             v = data[b-1];
        rxd = v;
        @(negedge clk);
      end
    end
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    if (!bad_stop) begin
      if (exp_q.size() < RX_DEPTH) exp_q.push_back(data);
      else                         exp_ovr = 1'b1;
    end
  endtask

  task automatic pop_one();
    bus.uart_re_n_i = 1'b0;
    @(negedge clk);
    bus.uart_re_n_i = 1'b1;
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      exp_ovr = 1'b0;
    end
    check_rx("pop");
  endtask

  initial begin
    logic [7:0] b;
    rst                = 1'b1;
    rxd                = 1'b1;
    bus.uart_we_n_i    = 1'b1;
    bus.uart_re_n_i    = 1'b1;
    bus.uart_tx_data_i = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tx_ready", 32'(bus.uart_tx_ready_o), 32'd1);
    check_rx("rst");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // TX: basic frame, dropped overlapping write, random bytes.
    tx_frame(8'h55, -1, 8'h00);
    repeat (10) @(negedge clk);
    tx_frame(8'h55, 100, 8'hAA);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      check("tx_no_second", 32'(txd), 32'd1);
      check("tx_ready_stays", 32'(bus.uart_tx_ready_o), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      tx_frame(8'($urandom), -1, 8'h00);
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    // RX: single byte then pop.
    rx_frame(8'hA5, 1'b0);
    check_rx("rx_a5");
    pop_one();

    // RX: overflow with 5 frames, then drain.
    for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b0);
    check_rx("rx_full");
    for (int i = 0; i < 5; i++) pop_one();

    // Glitch on start bit and framing error.
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    rxd = 1'b1;
    repeat (400) @(negedge clk);
    check_rx("rx_glitch");
    rx_frame(8'h3C, 1'b1);
    repeat (200) @(negedge clk);
    check_rx("rx_frame_err");

    // Random RX traffic with random pops.
    for (int i = 0; i < 4; i++) begin
      rx_frame(8'($urandom), 1'b0);
      check_rx("rx_rand");
      if ($urandom_range(0, 1) == 1) pop_one();
    end
    while (exp_q.size() != 0) pop_one();

    // Reset in the middle of a TX frame with a byte waiting in the RX FIFO.
    b = 8'($urandom);
    rx_frame(b, 1'b0);
    check_rx("rx_before_rst");
    bus.uart_tx_data_i = 8'hFF;
    bus.uart_we_n_i    = 1'b0;
    @(negedge clk);
    bus.uart_we_n_i = 1'b1;
    repeat (500) @(negedge clk);
    check("mid_tx_busy", 32'(bus.uart_tx_ready_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_ovr = 1'b0;
    check("rst_mid_txd", 32'(txd), 32'd1);
    check("rst_mid_ready", 32'(bus.uart_tx_ready_o), 32'd1);
    check_rx("rst_mid");
    repeat (50) @(negedge clk);
    check("post_rst_txd", 32'(txd), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
